cmm_arbiter: RTL and testbench

CMM_ARBITER -- requirements
Module: cmm_arbiter

---
 rtl/cmm_pkg.sv | 12 +
 rtl/cmm_arbiter_if.sv | 46 ++++
 rtl/cmm_tag_fifo.sv | 53 +++++
 rtl/cmm_arbiter.sv | 113 +++++++++++
 tb/tb_cmm_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmm_pkg.sv
// Shared defaults and types for the complex_matrix_mul arbiter slice.
package cmm_pkg;

  localparam int CMM_NUM_REQ      = 2;
  localparam int CMM_SIZE         = 16;
  localparam int CMM_NUM_OPERANDS = 4;
  localparam int CMM_WIDTH        = 64;
  localparam int CMM_MAX_INFLIGHT = 4;

  typedef logic [$clog2(CMM_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/cmm_arbiter_if.sv
// Requester and datapath handshake bundle around the shared matrix multiplier.
// The arbiter uses the master view; requesters plus datapath use the slave view.
interface cmm_arbiter_if import cmm_pkg::*; #(
  parameter int NUM_REQ      = CMM_NUM_REQ,
  parameter int SIZE         = CMM_SIZE,
  parameter int NUM_OPERANDS = CMM_NUM_OPERANDS,
  parameter int WIDTH        = CMM_WIDTH,
  parameter int MAX_INFLIGHT = CMM_MAX_INFLIGHT
);

  localparam int OPW   = SIZE * NUM_OPERANDS * WIDTH;
  localparam int RESW  = 2 * SIZE * WIDTH;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic                          flush_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0][OPW-1:0]   req_operands_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [NUM_REQ-1:0]            rsp_ready_i;
  logic [RESW-1:0]               rsp_result_o;
  logic                          dp_in_valid_o;
  logic                          dp_in_ready_i;
  logic [OPW-1:0]                dp_operands_o;
  logic                          dp_flush_o;
  logic                          dp_out_valid_i;
  logic                          dp_out_ready_o;
  logic [RESW-1:0]               dp_result_i;
  logic [CNT_W-1:0]              inflight_o;
  logic                          err_o;

  modport master (
    input  flush_i, req_valid_i, req_operands_i, rsp_ready_i,
           dp_in_ready_i, dp_out_valid_i, dp_result_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, dp_in_valid_o,
           dp_operands_o, dp_flush_o, dp_out_ready_o, inflight_o, err_o
  );

  modport slave (
    output flush_i, req_valid_i, req_operands_i, rsp_ready_i,
           dp_in_ready_i, dp_out_valid_i, dp_result_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, dp_in_valid_o,
           dp_operands_o, dp_flush_o, dp_out_ready_o, inflight_o, err_o
  );

endinterface

// File: rtl/cmm_tag_fifo.sv
// In-order FIFO of requester ids for issued, unreturned jobs.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cmm_tag_fifo import cmm_pkg::*; #(
  parameter int DEPTH = CMM_MAX_INFLIGHT,
  parameter int ID_W  = $bits(req_id_t)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [ID_W-1:0]          push_id_i,
  input  logic                     pop_i,
  output logic [ID_W-1:0]          head_id_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [ID_W-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign count_o   = wr_ptr - rd_ptr;
  assign full_o    = (count_o == CNT_W'(DEPTH));
  assign empty_o   = (count_o == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign head_id_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Tag storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr[AW-1:0]] <= push_id_i;
  end

endmodule

// File: rtl/cmm_arbiter.sv
// Round-robin arbiter sharing one complex_matrix_mul among NUM_REQ requesters.
// Purely combinational between handshakes; only rr_ptr, the tag FIFO and err are state.
module cmm_arbiter import cmm_pkg::*; #(
  parameter int NUM_REQ      = CMM_NUM_REQ,
  parameter int SIZE         = CMM_SIZE,
  parameter int NUM_OPERANDS = CMM_NUM_OPERANDS,
  parameter int WIDTH        = CMM_WIDTH,
  parameter int MAX_INFLIGHT = CMM_MAX_INFLIGHT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  cmm_arbiter_if.master bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  head_id;
  logic             any_req;
  logic             issue;
  logic             pop;
  logic             stray;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             err_q;

  // First valid requester at or after start, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    start);
    logic [ID_W-1:0] pick;
    logic [ID_W:0]   idx;
    logic            found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, start} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
    return pick;
  endfunction

  assign any_req = |bus.req_valid_i;
  assign gnt_id  = rr_pick(bus.req_valid_i, rr_ptr);

  // A full FIFO blocks issue even when a pop is pending, keeping the
  // response side from reaching the request side combinationally.
  assign bus.dp_in_valid_o = rst_ni & any_req & ~fifo_full & ~bus.flush_i;
  assign bus.dp_operands_o = bus.req_operands_i[gnt_id];
  assign bus.dp_flush_o    = bus.flush_i;
  assign issue             = bus.dp_in_valid_o & bus.dp_in_ready_i;

  always_comb begin
    bus.req_ready_o = '0;
    if (issue) bus.req_ready_o[gnt_id] = 1'b1;
  end

  // Results route to the oldest tag; with no tag the datapath still drains.
  always_comb begin
    bus.rsp_valid_o    = '0;
    bus.dp_out_ready_o = 1'b1;
    if (!fifo_empty && !bus.flush_i) begin
      bus.rsp_valid_o[head_id] = bus.dp_out_valid_i;
      bus.dp_out_ready_o       = bus.rsp_ready_i[head_id];
    end
  end

  assign bus.rsp_result_o = bus.dp_result_i;
  assign pop   = ~fifo_empty & ~bus.flush_i & bus.dp_out_valid_i & bus.dp_out_ready_o;
  assign stray = fifo_empty & bus.dp_out_valid_i;

  cmm_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .ID_W  (ID_W)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (bus.flush_i),
    .push_i    (issue),
    .push_id_i (gnt_id),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (stray) begin
      err_q <= 1'b1;
    end
  end

  assign bus.inflight_o = fifo_count;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_cmm_arbiter.sv
// Directed bench for cmm_arbiter: a cycle table plus hand sequences for stall,
// ordering, flush and asynchronous reset; the bench stands in for the datapath.
module tb_cmm_arbiter;
  import cmm_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int SIZE    = 16;
  localparam int NOPS    = 4;
  localparam int WIDTH   = 64;
  localparam int MAXI    = 4;
  localparam int OPW     = SIZE * NOPS * WIDTH;
  localparam int RESW    = 2 * SIZE * WIDTH;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  cmm_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE(SIZE), .NUM_OPERANDS(NOPS),
                   .WIDTH(WIDTH), .MAX_INFLIGHT(MAXI)) bus ();

  cmm_arbiter #(.NUM_REQ(NUM_REQ), .SIZE(SIZE), .NUM_OPERANDS(NOPS),
                .WIDTH(WIDTH), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [1:0] rv;
    logic       inr;
    logic       ov;
    logic [1:0] rr;
    logic       e_div;
    logic [1:0] e_rdy;
    logic       e_gnt;
    logic [1:0] e_rsv;
    logic       e_dor;
    logic [2:0] e_inf;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_wide(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got low word %0h expected low word %0h", name, act[63:0], exp[63:0]);
  endtask

  function automatic logic [OPW-1:0] make_ops(input real seed);
    logic [OPW-1:0] v;
    v = '0;
    for (int e = 0; e < SIZE; e++) begin
      v[(e*4+0)*WIDTH +: WIDTH] = $realtobits(seed + e * 0.25);
      v[(e*4+1)*WIDTH +: WIDTH] = $realtobits(-(e + 1) * 0.5);
      v[(e*4+2)*WIDTH +: WIDTH] = $realtobits(1.5 - e * 0.125);
      v[(e*4+3)*WIDTH +: WIDTH] = $realtobits(seed * 0.75);
    end
    return v;
  endfunction

  // Element-wise complex product standing in for the datapath result.
  function automatic logic [RESW-1:0] cmul(input logic [OPW-1:0] v);
    logic [RESW-1:0] r;
    real ar, ai, br, bi;
    r = '0;
    for (int e = 0; e < SIZE; e++) begin
      ar = $bitstoreal(v[(e*4+0)*WIDTH +: WIDTH]);
      ai = $bitstoreal(v[(e*4+1)*WIDTH +: WIDTH]);
      br = $bitstoreal(v[(e*4+2)*WIDTH +: WIDTH]);
      bi = $bitstoreal(v[(e*4+3)*WIDTH +: WIDTH]);
      r[(2*e)*WIDTH   +: WIDTH] = $realtobits(ar * br - ai * bi);
      r[(2*e+1)*WIDTH +: WIDTH] = $realtobits(ar * bi + ai * br);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i        = 1'b0;
    bus.req_valid_i    = '0;
    bus.rsp_ready_i    = '0;
    bus.dp_in_ready_i  = 1'b0;
    bus.dp_out_valid_i = 1'b0;
    bus.dp_result_i    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  logic [OPW-1:0]  ops_a, ops_b;
  logic [OPW-1:0]  job_ops [3];
  logic [1:0]      job_id  [3];
  logic [RESW-1:0] res;
  int              issued;

  initial begin
    ops_a = make_ops(1.0);
    ops_b = make_ops(2.0);

    tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 3'd1};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1, 3'd2};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 3'd2};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 3'd3};
    tbl[4]  = '{2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1, 2'b10, 1'b1, 3'd2};
    tbl[5]  = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3'd3};
    tbl[6]  = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3'd4};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 3'd3};
    tbl[8]  = '{2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd2};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd1};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 3'd1};
    tbl[11] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd0};
    tbl[12] = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 3'd1};
    tbl[13] = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 3'd1};
    tbl[14] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 3'd1};
    tbl[15] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd0};

    // Held in reset with live inputs: every output must sit at its reset value.
    idle();
    bus.req_operands_i[0] = ops_a;
    bus.req_operands_i[1] = ops_b;
    rst_ni = 1'b0;
    bus.req_valid_i    = 2'b11;
    bus.dp_in_ready_i  = 1'b1;
    bus.dp_out_valid_i = 1'b1;
    bus.rsp_ready_i    = 2'b11;
    #12;
    chk("rst_div",  64'(bus.dp_in_valid_o), 64'd0);
    chk("rst_rdy",  64'(bus.req_ready_o),   64'd0);
    chk("rst_rsv",  64'(bus.rsp_valid_o),   64'd0);
    chk("rst_inf",  64'(bus.inflight_o),    64'd0);
    chk("rst_err",  64'(bus.err_o),         64'd0);
    do_reset();

    // Cycle table: alternation, back-pressure, full blocking and in-order drain.
    for (int i = 0; i < 16; i++) begin
      bus.req_valid_i    = tbl[i].rv;
      bus.dp_in_ready_i  = tbl[i].inr;
      bus.dp_out_valid_i = tbl[i].ov;
      bus.rsp_ready_i    = tbl[i].rr;
      res = cmul(make_ops(real'(i)));
      bus.dp_result_i    = res;
      #1;
      chk($sformatf("t%0d_div", i), 64'(bus.dp_in_valid_o),  64'(tbl[i].e_div));
      chk($sformatf("t%0d_rdy", i), 64'(bus.req_ready_o),    64'(tbl[i].e_rdy));
      chk($sformatf("t%0d_rsv", i), 64'(bus.rsp_valid_o),    64'(tbl[i].e_rsv));
      chk($sformatf("t%0d_dor", i), 64'(bus.dp_out_ready_o), 64'(tbl[i].e_dor));
      if (tbl[i].e_div)
        chk_wide($sformatf("t%0d_ops", i), bus.dp_operands_o, tbl[i].e_gnt ? ops_b : ops_a);
      if (tbl[i].ov)
        chk_wide($sformatf("t%0d_res", i), OPW'(bus.rsp_result_o), OPW'(res));
      tick();
      chk($sformatf("t%0d_inf", i), 64'(bus.inflight_o), 64'(tbl[i].e_inf));
      chk($sformatf("t%0d_err", i), 64'(bus.err_o),      64'd0);
    end

    // Only requester 1 for three jobs, then the pointer is back at 0.
    do_reset();
    bus.req_valid_i   = 2'b10;
    bus.dp_in_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("only1_rdy%0d", k), 64'(bus.req_ready_o), 64'b10);
      tick();
    end
    bus.req_valid_i   = 2'b11;
    bus.dp_in_ready_i = 1'b0;
    #1;
    chk("only1_inf", 64'(bus.inflight_o), 64'd3);
    chk_wide("only1_next_gnt0", bus.dp_operands_o, ops_a);

    // Results stalled, five jobs offered: only MAX_INFLIGHT issue.
    do_reset();
    bus.req_valid_i   = 2'b01;
    bus.dp_in_ready_i = 1'b1;
    issued = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_div%0d", k), 64'(bus.dp_in_valid_o), (k < 4) ? 64'd1 : 64'd0);
      if (bus.req_ready_o[0]) issued++;
      tick();
    end
    chk("stall_issued", 64'(issued), 64'd4);
    chk("stall_inf",    64'(bus.inflight_o), 64'd4);
    bus.dp_out_valid_i = 1'b1;
    bus.rsp_ready_i    = 2'b01;
    #1;
    chk("stall_pop_div", 64'(bus.dp_in_valid_o), 64'd0);
    chk("stall_pop_rsv", 64'(bus.rsp_valid_o),   64'b01);
    tick();
    bus.dp_out_valid_i = 1'b0;
    #1;
    chk("stall_after_inf", 64'(bus.inflight_o),    64'd3);
    chk("stall_after_div", 64'(bus.dp_in_valid_o), 64'd1);

    // Issue order 0,1,0 then results return in the same order.
    do_reset();
    job_ops[0] = make_ops(3.0);  job_id[0] = 2'b01;
    job_ops[1] = make_ops(-1.5); job_id[1] = 2'b10;
    job_ops[2] = make_ops(0.5);  job_id[2] = 2'b01;
    bus.dp_in_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (job_id[k] == 2'b01) bus.req_operands_i[0] = job_ops[k];
      else                    bus.req_operands_i[1] = job_ops[k];
      bus.req_valid_i = job_id[k];
      #1;
      chk($sformatf("ord_rdy%0d", k), 64'(bus.req_ready_o), 64'(job_id[k]));
      chk_wide($sformatf("ord_ops%0d", k), bus.dp_operands_o, job_ops[k]);
      tick();
    end
    bus.req_valid_i    = 2'b00;
    bus.rsp_ready_i    = 2'b11;
    bus.dp_out_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      res = cmul(job_ops[k]);
      bus.dp_result_i = res;
      #1;
      chk($sformatf("ord_rsv%0d", k), 64'(bus.rsp_valid_o), 64'(job_id[k]));
      chk_wide($sformatf("ord_res%0d", k), OPW'(bus.rsp_result_o), OPW'(res));
      tick();
    end
    bus.dp_out_valid_i = 1'b0;
    chk("ord_inf", 64'(bus.inflight_o), 64'd0);
    chk("ord_err", 64'(bus.err_o),      64'd0);

    // Flush with three jobs in flight, then a late stray result.
    do_reset();
    bus.req_operands_i[0] = ops_a;
    bus.req_operands_i[1] = ops_b;
    bus.req_valid_i   = 2'b01;
    bus.dp_in_ready_i = 1'b1;
    repeat (3) tick();
    chk("fl_inf_before", 64'(bus.inflight_o), 64'd3);
    bus.flush_i        = 1'b1;
    bus.req_valid_i    = 2'b11;
    bus.dp_out_valid_i = 1'b1;
    bus.rsp_ready_i    = 2'b11;
    #1;
    chk("fl_dp_flush", 64'(bus.dp_flush_o),    64'd1);
    chk("fl_div",      64'(bus.dp_in_valid_o), 64'd0);
    chk("fl_rdy",      64'(bus.req_ready_o),   64'd0);
    chk("fl_rsv",      64'(bus.rsp_valid_o),   64'd0);
    tick();
    bus.flush_i        = 1'b0;
    bus.req_valid_i    = 2'b00;
    bus.dp_out_valid_i = 1'b0;
    #1;
    chk("fl_inf_after", 64'(bus.inflight_o), 64'd0);
    chk("fl_err_after", 64'(bus.err_o),      64'd0);
    bus.dp_out_valid_i = 1'b1;
    #1;
    chk("late_rsv", 64'(bus.rsp_valid_o),    64'd0);
    chk("late_dor", 64'(bus.dp_out_ready_o), 64'd1);
    tick();
    bus.dp_out_valid_i = 1'b0;
    chk("late_err", 64'(bus.err_o), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    tick();
    chk("err_sticky", 64'(bus.err_o), 64'd1);
    bus.req_valid_i   = 2'b11;
    bus.dp_in_ready_i = 1'b0;
    #1;
    chk_wide("fl_rr_kept", bus.dp_operands_o, ops_b);

    // Asynchronous reset dropped between edges while an issue is offered.
    bus.req_valid_i   = 2'b01;
    bus.dp_in_ready_i = 1'b1;
    tick();
    chk("ar_inf_before", 64'(bus.inflight_o), 64'd1);
    bus.req_valid_i    = 2'b11;
    bus.dp_out_valid_i = 1'b1;
    bus.rsp_ready_i    = 2'b11;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_inf", 64'(bus.inflight_o),    64'd0);
    chk("ar_err", 64'(bus.err_o),         64'd0);
    chk("ar_div", 64'(bus.dp_in_valid_o), 64'd0);
    chk("ar_rdy", 64'(bus.req_ready_o),   64'd0);
    chk("ar_rsv", 64'(bus.rsp_valid_o),   64'd0);
    idle();
    tick();
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
